// File: rtl/sn_ring_master.sv
// sn_ring_master: initiator for the SN control ring.
//
// Accepts one host command at a time and drives it into the head of the tile
// chain. It then waits for the ack/done pair to come back from the chain tail
// and returns a response (completion or timeout) to the host.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   cmd_valid / cmd_ready     host command handshake (op/tile/addr/len)
//   ring_op/tile/addr/len     command fields driven into the chain head
//   ring_ack, ring_done       returning ack/done from the chain tail
//   rsp_valid / rsp_ready     response handshake (err/tile/cycles)
//   dbg_state                 current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. The command side is ready only in IDLE. Once rsp_valid rises, it and the
// rsp_* fields stay stable until the transfer.
module sn_ring_master #(
  parameter int TILE_WIDTH     = 4,
  parameter int ADDR_WIDTH     = 64,
  parameter int WL_LEN_BITS    = 32,
  parameter int OP_WIDTH       = 2,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [OP_WIDTH-1:0]    cmd_op,
  input  logic [TILE_WIDTH-1:0]  cmd_tile,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [WL_LEN_BITS-1:0] cmd_len,
  output logic [OP_WIDTH-1:0]    ring_op,
  output logic [TILE_WIDTH-1:0]  ring_tile,
  output logic [ADDR_WIDTH-1:0]  ring_addr,
  output logic [WL_LEN_BITS-1:0] ring_len,
  input  logic                   ring_ack,
  input  logic                   ring_done,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_err,
  output logic [TILE_WIDTH-1:0]  rsp_tile,
  output logic [CNT_WIDTH-1:0]   rsp_cycles,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SEND      = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_RESP      = 2'd3
  } state_e;

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT_CYCLES);

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic [OP_WIDTH-1:0]    ring_op_q, ring_op_d;
  logic [TILE_WIDTH-1:0]  ring_tile_q, ring_tile_d;
  logic [ADDR_WIDTH-1:0]  ring_addr_q, ring_addr_d;
  logic [WL_LEN_BITS-1:0] ring_len_q, ring_len_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [TILE_WIDTH-1:0]  rsp_tile_q, rsp_tile_d;
  logic [CNT_WIDTH-1:0]   rsp_cycles_q, rsp_cycles_d;

  // cnt_inc is the count including the current SEND/WAIT_DONE cycle; it is
  // what gets reported if the command finishes in this cycle.
  logic [CNT_WIDTH-1:0]   cnt_inc;
  logic                   timeout_hit;

  assign cnt_inc     = cnt_q + 1'b1;
  assign timeout_hit = (cnt_inc == TIMEOUT_CNT);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cmd_ready_d  = cmd_ready_q;
    ring_op_d    = ring_op_q;
    ring_tile_d  = ring_tile_q;
    ring_addr_d  = ring_addr_q;
    ring_len_d   = ring_len_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_err_d    = rsp_err_q;
    rsp_tile_d   = rsp_tile_q;
    rsp_cycles_d = rsp_cycles_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          ring_op_d   = cmd_op;
          ring_tile_d = cmd_tile;
          ring_addr_d = cmd_addr;
          ring_len_d  = cmd_len;
          cnt_d       = '0;
          cmd_ready_d = 1'b0;
          state_d     = S_SEND;
        end
      end

      S_SEND: begin
        cnt_d = cnt_inc;
        // done is only meaningful together with (or after) ack; a lone done
        // in SEND is ignored, so it cannot rescue a timeout here.
        if (ring_ack && ring_done) begin
          ring_op_d    = '0;
          rsp_valid_d  = 1'b1;
          rsp_err_d    = 1'b0;
          rsp_tile_d   = ring_tile_q;
          rsp_cycles_d = cnt_inc;
          state_d      = S_RESP;
        end else if (timeout_hit) begin
          ring_op_d    = '0;
          rsp_valid_d  = 1'b1;
          rsp_err_d    = 1'b1;
          rsp_tile_d   = ring_tile_q;
          rsp_cycles_d = cnt_inc;
          state_d      = S_RESP;
        end else if (ring_ack) begin
          ring_op_d = '0;
          state_d   = S_WAIT_DONE;
        end
      end

      S_WAIT_DONE: begin
        cnt_d = cnt_inc;
        // done takes priority over a timeout landing in the same cycle.
        if (ring_done || timeout_hit) begin
          rsp_valid_d  = 1'b1;
          rsp_err_d    = !ring_done;
          rsp_tile_d   = ring_tile_q;
          rsp_cycles_d = cnt_inc;
          state_d      = S_RESP;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cmd_ready_q  <= 1'b1;
      ring_op_q    <= '0;
      ring_tile_q  <= '0;
      ring_addr_q  <= '0;
      ring_len_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_tile_q   <= '0;
      rsp_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_ready_q  <= cmd_ready_d;
      ring_op_q    <= ring_op_d;
      ring_tile_q  <= ring_tile_d;
      ring_addr_q  <= ring_addr_d;
      ring_len_q   <= ring_len_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_tile_q   <= rsp_tile_d;
      rsp_cycles_q <= rsp_cycles_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign ring_op    = ring_op_q;
  assign ring_tile  = ring_tile_q;
  assign ring_addr  = ring_addr_q;
  assign ring_len   = ring_len_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_tile   = rsp_tile_q;
  assign rsp_cycles = rsp_cycles_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sn_ring_master.sv
// Testbench for sn_ring_master. Inputs are driven 1 time unit after each
// rising edge, and outputs are sampled at that same point, once they have
// settled after the edge.
module tb_sn_ring_master;

  localparam int TW = 4;
  localparam int AW = 64;
  localparam int LW = 32;
  localparam int OW = 2;
  localparam int CW = 16;
  localparam int T  = 8;
  localparam int RW = 1 + TW + CW;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [OW-1:0] cmd_op;
  logic [TW-1:0] cmd_tile;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [OW-1:0] ring_op;
  logic [TW-1:0] ring_tile;
  logic [AW-1:0] ring_addr;
  logic [LW-1:0] ring_len;
  logic          ring_ack;
  logic          ring_done;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_err;
  logic [TW-1:0] rsp_tile;
  logic [CW-1:0] rsp_cycles;
  logic [1:0]    dbg_state;

  int n_tests;
  int n_fail;

  // Scoreboard: expected responses {err, tile, cycles} in issue order.
  logic [RW-1:0] exp_q[$];

  sn_ring_master #(
    .TILE_WIDTH(TW), .ADDR_WIDTH(AW), .WL_LEN_BITS(LW), .OP_WIDTH(OW),
    .CNT_WIDTH(CW), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_tile(cmd_tile), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .ring_op(ring_op), .ring_tile(ring_tile), .ring_addr(ring_addr), .ring_len(ring_len),
    .ring_ack(ring_ack), .ring_done(ring_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_err(rsp_err), .rsp_tile(rsp_tile), .rsp_cycles(rsp_cycles),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: with ack in SEND cycle a and done in cycle d (d >= a),
  // the command completes at cycle d if d <= T, else it times out at cycle T.
  function automatic logic [RW-1:0] model_rsp(input int a, input int d, input logic [TW-1:0] tile);
    logic       err;
    logic [CW-1:0] cyc;
    err = (d > T);
    cyc = (d > T) ? CW'(T) : CW'(d);
    return {err, tile, cyc};
  endfunction

  // Driver: issue one command, return ack in cycle a and done in cycle d,
  // then hold off rsp_ready for rdly cycles while toggling ring inputs.
  task automatic run_cmd(input logic [OW-1:0] op, input logic [TW-1:0] tile,
                         input logic [AW-1:0] addr, input logic [LW-1:0] len,
                         input int a, input int d, input int rdly);
    logic [RW-1:0] exp_rsp;
    int            n_cyc;
    int            waited;
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd_ready_wait: got %b want 1", cmd_ready);
    end
    exp_q.push_back(model_rsp(a, d, tile));
    n_cyc = (d > T) ? T : d;
    cmd_valid = 1'b1;
    cmd_op = op; cmd_tile = tile; cmd_addr = addr; cmd_len = len;
    step();
    cmd_valid = 1'b0;
    cmd_op = OW'($urandom); cmd_tile = TW'($urandom);
    cmd_addr = {$urandom, $urandom}; cmd_len = $urandom;
    for (int k = 1; k <= n_cyc; k++) begin
      n_tests++;
      if (ring_op !== ((k <= a) ? op : OW'(0))) begin
        n_fail++;
        $display("FAIL ring_op c%0d: got %0d want %0d", k, ring_op, (k <= a) ? op : OW'(0));
      end
      n_tests++;
      if (ring_tile !== tile || ring_addr !== addr || ring_len !== len) begin
        n_fail++;
        $display("FAIL ring_fields c%0d: got %h/%h/%h want %h/%h/%h", k,
                 ring_tile, ring_addr, ring_len, tile, addr, len);
      end
      n_tests++;
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL busy c%0d: got ready=%b rsp_valid=%b want 0/0", k, cmd_ready, rsp_valid);
      end
      ring_ack  = (k == a) ? 1'b1 : ((k > a) ? 1'($urandom) : 1'b0);
      ring_done = (k == d);
      step();
    end
    ring_ack = 1'b0; ring_done = 1'b0;
    exp_rsp = exp_q.pop_front();
    for (int r = 0; r <= rdly; r++) begin
      n_tests++;
      if (rsp_valid !== 1'b1 || {rsp_err, rsp_tile, rsp_cycles} !== exp_rsp) begin
        n_fail++;
        $display("FAIL rsp r%0d: got v=%b {err,tile,cyc}=%h want v=1 %h", r,
                 rsp_valid, {rsp_err, rsp_tile, rsp_cycles}, exp_rsp);
      end
      n_tests++;
      if (ring_op !== '0 || cmd_ready !== 1'b0 || ring_tile !== tile) begin
        n_fail++;
        $display("FAIL resp_idle r%0d: got op=%0d ready=%b tile=%h want 0/0/%h", r,
                 ring_op, cmd_ready, ring_tile, tile);
      end
      if (r < rdly) begin
        rsp_ready = 1'b0;
        ring_ack  = 1'($urandom);
        ring_done = 1'($urandom);
        cmd_valid = 1'b1;  // must not be accepted while a response is pending
      end else begin
        rsp_ready = 1'b1;
        ring_ack  = 1'b0;
        ring_done = 1'b0;
        cmd_valid = 1'b0;
      end
      step();
    end
    rsp_ready = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || ring_op !== '0) begin
      n_fail++;
      $display("FAIL after_rsp: got v=%b ready=%b op=%0d want 0/1/0", rsp_valid, cmd_ready, ring_op);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    n_tests++;
    if (cmd_ready !== 1'b1 || ring_op !== '0 || ring_tile !== '0 || ring_addr !== '0 ||
        ring_len !== '0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_tile !== '0 ||
        rsp_cycles !== '0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL %s: got rdy=%b op=%0d tile=%h addr=%h len=%h rv=%b err=%b rt=%h rc=%0d st=%0d want reset values",
               tag, cmd_ready, ring_op, ring_tile, ring_addr, ring_len, rsp_valid, rsp_err,
               rsp_tile, rsp_cycles, dbg_state);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_reset_vals("reset_values");
    ring_ack = 1'b1; ring_done = 1'b1;
    step();
    ring_ack = 1'b0; ring_done = 1'b0;
    step();
    check_reset_vals("idle_spurious");
  endtask

  task automatic test_delayed_done();
    run_cmd(2'd1, 4'd3, 64'h1000, 32'd64, 2, 5, 0);
  endtask

  task automatic test_back_to_back();
    // Command A accepted at edge E, command B must be accepted at E+3.
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_tile = 4'd5; cmd_addr = 64'hA; cmd_len = 32'd1;
    step();
    n_tests++;
    if (ring_op !== 2'd2 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_send: got op=%0d ready=%b want 2/0", ring_op, cmd_ready);
    end
    ring_ack = 1'b1; ring_done = 1'b1; rsp_ready = 1'b1;
    cmd_op = 2'd3; cmd_tile = 4'd9; cmd_addr = 64'hB; cmd_len = 32'd2;
    step();
    ring_ack = 1'b0; ring_done = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_cycles !== 16'd1 || rsp_tile !== 4'd5 ||
        ring_op !== '0) begin
      n_fail++;
      $display("FAIL b2b_rsp: got v=%b err=%b cyc=%0d tile=%0d op=%0d want 1/0/1/5/0",
               rsp_valid, rsp_err, rsp_cycles, rsp_tile, ring_op);
    end
    step();
    n_tests++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || ring_tile !== 4'd5) begin
      n_fail++;
      $display("FAIL b2b_idle: got ready=%b v=%b tile=%0d want 1/0/5", cmd_ready, rsp_valid, ring_tile);
    end
    step();
    cmd_valid = 1'b0;
    n_tests++;
    if (ring_op !== 2'd3 || ring_tile !== 4'd9 || ring_addr !== 64'hB || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: got op=%0d tile=%0d addr=%h ready=%b want 3/9/b/0",
               ring_op, ring_tile, ring_addr, cmd_ready);
    end
    ring_ack = 1'b1; ring_done = 1'b1;
    step();
    ring_ack = 1'b0; ring_done = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_tile !== 4'd9 || rsp_cycles !== 16'd1) begin
      n_fail++;
      $display("FAIL b2b_second_rsp: got v=%b tile=%0d cyc=%0d want 1/9/1", rsp_valid, rsp_tile, rsp_cycles);
    end
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    run_cmd(2'd1, 4'd7, 64'h2000, 32'd8, 1, 1000, 1);   // ack, no done
    run_cmd(2'd2, 4'd6, 64'h3000, 32'd9, 1, T, 0);      // done lands on timeout cycle
    run_cmd(2'd3, 4'd4, 64'h4000, 32'd3, 1000, 1000, 0); // no ack at all
  endtask

  task automatic test_backpressure();
    run_cmd(2'd1, 4'd2, 64'hDEAD_BEEF, 32'd5, 1, 3, 10);
  endtask

  task automatic test_reset_mid_cmd();
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_tile = 4'd12; cmd_addr = 64'h55; cmd_len = 32'd7;
    step();
    cmd_valid = 1'b0;
    ring_ack = 1'b1;
    step();
    ring_ack = 1'b0;
    step();
    step();  // now in WAIT_DONE
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_vals("mid_reset");
    ring_done = 1'b1;
    step();
    ring_done = 1'b0;
    step();
    n_tests++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL late_done: got v=%b ready=%b want 0/1", rsp_valid, cmd_ready);
    end
    run_cmd(2'd2, 4'd10, 64'h77, 32'd11, 2, 4, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      int a;
      int d;
      a = $urandom_range(1, T + 2);
      d = a + $urandom_range(0, 4);
      run_cmd(OW'($urandom_range(1, 3)), TW'($urandom), {$urandom, $urandom}, $urandom,
              a, d, $urandom_range(0, 3));
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_tile = '0; cmd_addr = '0; cmd_len = '0;
    ring_ack = 1'b0; ring_done = 1'b0; rsp_ready = 1'b0;
    #1;
    test_reset();
    test_delayed_done();
    test_back_to_back();
    test_timeout();
    test_backpressure();
    test_reset_mid_cmd();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
